tage_bank: RTL and testbench

//  Parametrised tagged TAGE component bank: ctr/tag/useful arrays with a 1-cycle lookup port.
//  Has a decoupled update port that carries its own index.

---
 rtl/tage_pkg.sv | 22 ++
 rtl/tage_sweep_ctrl.sv | 95 +++++++++
 rtl/tage_bank.sv | 155 +++++++++++++++
 tb/tb_tage_bank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tage_pkg.sv
// Shared state type and counter helpers for the tagged TAGE bank and its sweep controller.
package tage_pkg;

  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, AGE = 2'd2} tage_state_e;

  function automatic logic [31:0] weak_taken(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  function automatic logic [31:0] weak_ntaken(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    return (v == ((32'd1 << w) - 32'd1)) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? v : v - 32'd1;
  endfunction

endpackage

// File: rtl/tage_sweep_ctrl.sv
// Sweep controller: reset-time init walk, aging-period counter and useful-bit aging walk.
module tage_sweep_ctrl
  import tage_pkg::*;
#(
  parameter int IDX_W        = 10,
  parameter int U_W          = 2,
  parameter int U_AGE_PERIOD = 262144,
  localparam int COL_W       = (U_W > 1) ? $clog2(U_W) : 1,
  localparam int CNT_W       = $clog2(U_AGE_PERIOD)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             upd_v_i,
  output logic             sweep_we_o,
  output logic [IDX_W-1:0] sweep_idx_o,
  output tage_state_e      mode_o,
  output logic [COL_W-1:0] age_col_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(U_AGE_PERIOD - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(U_W - 1);

  tage_state_e      r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic             w_we;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= INIT;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // An update in AGE owns the array write port, so the aging walk stalls that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_col_nxt   = r_col;
    w_we        = 1'b0;
    case (r_state)
      INIT: begin
        w_we      = 1'b1;
        w_ptr_nxt = r_ptr + IDX_W'(1'b1);
        if (r_ptr == LAST_IDX) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = INIT;
        end
      end
      RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = AGE;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1'b1);
        end
      end
      AGE: begin
        if (upd_v_i) begin
          w_we = 1'b0;
        end else begin
          w_we      = 1'b1;
          w_ptr_nxt = r_ptr + IDX_W'(1'b1);
          if (r_ptr == LAST_IDX) begin
            w_state_nxt = RUN;
            w_col_nxt   = (r_col == COL_LAST) ? '0 : r_col + COL_W'(1'b1);
          end else begin
            w_state_nxt = AGE;
          end
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign sweep_we_o  = w_we;
  assign sweep_idx_o = r_ptr;
  assign mode_o      = r_state;
  assign age_col_o   = r_col;

endmodule

// File: rtl/tage_bank.sv
// Tagged TAGE component bank: ctr/tag/useful arrays, registered lookup with write-first
// bypass from the single array write port (init sweep, update, or useful-bit aging).
module tage_bank
  import tage_pkg::*;
#(
  parameter int IDX_W        = 10,
  parameter int TAG_W        = 9,
  parameter int CTR_W        = 3,
  parameter int U_W          = 2,
  parameter int U_AGE_PERIOD = 262144
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             ready_o,
  input  logic             lkp_v_i,
  input  logic [IDX_W-1:0] lkp_idx_i,
  input  logic [TAG_W-1:0] lkp_tag_i,
  output logic             pred_v_o,
  output logic             pred_taken_o,
  output logic             tag_hit_o,
  output logic [U_W-1:0]   u_o,
  output logic             new_entry_o,
  input  logic             upd_v_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic [TAG_W-1:0] upd_tag_i,
  input  logic             upd_taken_i,
  input  logic             upd_alloc_i,
  input  logic             upd_provider_i,
  input  logic             upd_u_en_i,
  input  logic             upd_dec_u_i
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int COL_W = (U_W > 1) ? $clog2(U_W) : 1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(weak_ntaken(CTR_W));

  logic [CTR_W-1:0] r_ctr [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [U_W-1:0]   r_u   [DEPTH];

  tage_state_e      w_mode;
  logic             w_sweep_we, w_ready, w_upd_we, w_we;
  logic [IDX_W-1:0] w_sweep_idx, w_widx;
  logic [COL_W-1:0] w_age_col;
  logic [CTR_W-1:0] w_old_ctr, w_ctr_wr, w_lkp_ctr;
  logic [TAG_W-1:0] w_old_tag, w_tag_wr, w_lkp_tag;
  logic [U_W-1:0]   w_old_u, w_u_wr, w_lkp_u;

  logic             r_pred_v, r_taken, r_hit, r_new;
  logic [U_W-1:0]   r_pred_u;

  tage_sweep_ctrl #(
    .IDX_W        (IDX_W),
    .U_W          (U_W),
    .U_AGE_PERIOD (U_AGE_PERIOD)
  ) u_sweep (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .upd_v_i     (upd_v_i),
    .sweep_we_o  (w_sweep_we),
    .sweep_idx_o (w_sweep_idx),
    .mode_o      (w_mode),
    .age_col_o   (w_age_col)
  );

  // Next contents of the entry on the write port; priority alloc > provider > dec_u.
  always_comb begin
    w_ready   = (w_mode != INIT);
    w_upd_we  = upd_v_i && w_ready;
    w_we      = w_upd_we || w_sweep_we;
    w_widx    = w_upd_we ? upd_idx_i : w_sweep_idx;
    w_old_ctr = r_ctr[w_widx];
    w_old_tag = r_tag[w_widx];
    w_old_u   = r_u[w_widx];
    w_ctr_wr  = w_old_ctr;
    w_tag_wr  = w_old_tag;
    w_u_wr    = w_old_u;
    if (w_mode == INIT) begin
      w_ctr_wr = '0;
      w_tag_wr = '0;
      w_u_wr   = '0;
    end else if (w_upd_we) begin
      if (upd_alloc_i) begin
        w_ctr_wr = upd_taken_i ? CTR_WT : CTR_WNT;
        w_tag_wr = upd_tag_i;
        w_u_wr   = '0;
      end else begin
        if (upd_provider_i) begin
          w_ctr_wr = upd_taken_i ? CTR_W'(sat_inc(32'(w_old_ctr), CTR_W))
                                 : CTR_W'(sat_dec(32'(w_old_ctr)));
        end else begin
          w_ctr_wr = w_old_ctr;
        end
        if (upd_provider_i && upd_u_en_i) begin
          w_u_wr = (upd_taken_i == w_old_ctr[CTR_W-1]) ? U_W'(sat_inc(32'(w_old_u), U_W))
                                                        : U_W'(sat_dec(32'(w_old_u)));
        end else if (upd_dec_u_i) begin
          w_u_wr = U_W'(sat_dec(32'(w_old_u)));
        end else begin
          w_u_wr = w_old_u;
        end
      end
    end else begin
      w_u_wr = w_old_u & ~(U_W'(1'b1) << w_age_col);
    end
  end

  // Write-first read: a same-cycle write to the looked-up index is forwarded.
  always_comb begin
    if (w_we && (w_widx == lkp_idx_i)) begin
      w_lkp_ctr = w_ctr_wr;
      w_lkp_tag = w_tag_wr;
      w_lkp_u   = w_u_wr;
    end else begin
      w_lkp_ctr = r_ctr[lkp_idx_i];
      w_lkp_tag = r_tag[lkp_idx_i];
      w_lkp_u   = r_u[lkp_idx_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_we) begin
      r_ctr[w_widx] <= w_ctr_wr;
      r_tag[w_widx] <= w_tag_wr;
      r_u[w_widx]   <= w_u_wr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pred_v <= 1'b0;
      r_taken  <= 1'b0;
      r_hit    <= 1'b0;
      r_pred_u <= '0;
      r_new    <= 1'b0;
    end else begin
      r_pred_v <= lkp_v_i && w_ready;
      if (lkp_v_i && w_ready) begin
        r_taken  <= w_lkp_ctr[CTR_W-1];
        r_hit    <= (w_lkp_tag == lkp_tag_i);
        r_pred_u <= w_lkp_u;
        r_new    <= ((w_lkp_ctr == CTR_WT) || (w_lkp_ctr == CTR_WNT)) && (w_lkp_u == '0);
      end
    end
  end

  assign ready_o      = w_ready;
  assign pred_v_o     = r_pred_v;
  assign pred_taken_o = r_taken;
  assign tag_hit_o    = r_hit;
  assign u_o          = r_pred_u;
  assign new_entry_o  = r_new;

endmodule

// File: tb/tb_tage_bank.sv
// Scoreboard bench for tage_bank: a default bank and a small fast-aging bank (8 entries, period 16).
module tb_tage_bank;

  localparam int IDX_W   = 10;
  localparam int A_IDX_W = 3;
  localparam int TAG_W   = 9;

  typedef logic [4:0] resp_t;  // {taken, hit, u[1:0], new_entry}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, ready, lkp_v, pred_v, pred_taken, tag_hit, new_entry;
  logic [IDX_W-1:0]   lkp_idx, upd_idx;
  logic [TAG_W-1:0]   lkp_tag, upd_tag;
  logic [1:0]         u;
  logic               upd_v, upd_taken, upd_alloc, upd_provider, upd_u_en, upd_dec_u;

  logic               a_rst, a_ready, a_lkp_v, a_pred_v, a_pred_taken, a_tag_hit, a_new_entry;
  logic [A_IDX_W-1:0] a_lkp_idx, a_upd_idx;
  logic [TAG_W-1:0]   a_lkp_tag, a_upd_tag;
  logic [1:0]         a_u;
  logic               a_upd_v, a_upd_taken, a_upd_alloc, a_upd_provider, a_upd_u_en, a_upd_dec_u;

  tage_bank u_dut (
    .clk_i(clk), .rst_i(rst), .ready_o(ready),
    .lkp_v_i(lkp_v), .lkp_idx_i(lkp_idx), .lkp_tag_i(lkp_tag),
    .pred_v_o(pred_v), .pred_taken_o(pred_taken), .tag_hit_o(tag_hit), .u_o(u),
    .new_entry_o(new_entry),
    .upd_v_i(upd_v), .upd_idx_i(upd_idx), .upd_tag_i(upd_tag), .upd_taken_i(upd_taken),
    .upd_alloc_i(upd_alloc), .upd_provider_i(upd_provider), .upd_u_en_i(upd_u_en),
    .upd_dec_u_i(upd_dec_u)
  );

  tage_bank #(.IDX_W(A_IDX_W), .U_AGE_PERIOD(16)) u_age (
    .clk_i(clk), .rst_i(a_rst), .ready_o(a_ready),
    .lkp_v_i(a_lkp_v), .lkp_idx_i(a_lkp_idx), .lkp_tag_i(a_lkp_tag),
    .pred_v_o(a_pred_v), .pred_taken_o(a_pred_taken), .tag_hit_o(a_tag_hit), .u_o(a_u),
    .new_entry_o(a_new_entry),
    .upd_v_i(a_upd_v), .upd_idx_i(a_upd_idx), .upd_tag_i(a_upd_tag), .upd_taken_i(a_upd_taken),
    .upd_alloc_i(a_upd_alloc), .upd_provider_i(a_upd_provider), .upd_u_en_i(a_upd_u_en),
    .upd_dec_u_i(a_upd_dec_u)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  resp_t q_m[$];
  resp_t q_a[$];
  int    a_pe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic resp_t resp(input logic t, input logic h, input logic [1:0] uu, input logic n);
    return {t, h, uu, n};
  endfunction

  // Rising edges of the small bank since its reset was released.
  always @(posedge clk or posedge a_rst) begin
    if (a_rst) a_pe <= 0;
    else       a_pe <= a_pe + 1;
  end

  // Monitors: every presented prediction pops one expected response.
  always @(negedge clk) begin
    if (pred_v === 1'b1) begin
      check("lkp_m_pending", 32'(q_m.size() > 0), 32'd1);
      if (q_m.size() > 0)
        check("lkp_m", {27'd0, pred_taken, tag_hit, u, new_entry}, {27'd0, q_m.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (a_pred_v === 1'b1) begin
      check("lkp_a_pending", 32'(q_a.size() > 0), 32'd1);
      if (q_a.size() > 0)
        check("lkp_a", {27'd0, a_pred_taken, a_tag_hit, a_u, a_new_entry}, {27'd0, q_a.pop_front()});
    end
  end

  task automatic op(input bit a, input bit lv, input int li, input int lt, input resp_t ex,
                    input bit uv, input int ui, input int ut,
                    input bit tk, input bit al, input bit pr, input bit ue, input bit du);
    if (a) begin
      a_lkp_v = lv; a_lkp_idx = A_IDX_W'(li); a_lkp_tag = TAG_W'(lt);
      a_upd_v = uv; a_upd_idx = A_IDX_W'(ui); a_upd_tag = TAG_W'(ut);
      a_upd_taken = tk; a_upd_alloc = al; a_upd_provider = pr; a_upd_u_en = ue; a_upd_dec_u = du;
      if (lv) q_a.push_back(ex);
    end else begin
      lkp_v = lv; lkp_idx = IDX_W'(li); lkp_tag = TAG_W'(lt);
      upd_v = uv; upd_idx = IDX_W'(ui); upd_tag = TAG_W'(ut);
      upd_taken = tk; upd_alloc = al; upd_provider = pr; upd_u_en = ue; upd_dec_u = du;
      if (lv) q_m.push_back(ex);
    end
    @(negedge clk);
    lkp_v = 1'b0; upd_v = 1'b0; a_lkp_v = 1'b0; a_upd_v = 1'b0;
  endtask

  task automatic lookup(input bit a, input int li, input int lt, input resp_t ex);
    op(a, 1'b1, li, lt, ex, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic update(input bit a, input int ui, input int ut,
                        input bit tk, input bit al, input bit pr, input bit ue, input bit du);
    op(a, 1'b0, 0, 0, 5'd0, 1'b1, ui, ut, tk, al, pr, ue, du);
  endtask

  task automatic wait_ready(input bit a, input int exp_len, input string name);
    int n = 0;
    while (((a ? a_ready : ready) !== 1'b1) && (n < 5000)) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(n), 32'(exp_len));
  endtask

  task automatic a_wait_pe(input int n);
    while (a_pe < n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; a_rst = 1'b1;
    op(1'b0, 1'b0, 0, 0, 5'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 0, 0, 5'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_pred_v", 32'(pred_v), 32'd0);
    rst = 1'b0;
    wait_ready(1'b0, 1024, "init_len");

    lookup(1'b0, 5, 0, resp(1'b0, 1'b1, 2'd0, 1'b0));
    update(1'b0, 7, 'h1A3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    lookup(1'b0, 7, 'h1A3, resp(1'b1, 1'b1, 2'd0, 1'b1));
    repeat (5) update(1'b0, 7, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    lookup(1'b0, 7, 'h1A3, resp(1'b1, 1'b1, 2'd0, 1'b0));
    update(1'b0, 7, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    lookup(1'b0, 7, 'h1A3, resp(1'b1, 1'b1, 2'd0, 1'b0));
    lookup(1'b0, 7, 'h0A3, resp(1'b1, 1'b0, 2'd0, 1'b0));
    // Same-cycle update and lookup of one index: forwarded entry.
    op(1'b0, 1'b1, 3, 'h055, resp(1'b0, 1'b1, 2'd0, 1'b1), 1'b1, 3, 'h055, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 7, 'h1A3, resp(1'b1, 1'b1, 2'd0, 1'b0), 1'b1, 7, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    op(1'b0, 1'b1, 7, 'h1A3, resp(1'b1, 1'b1, 2'd0, 1'b1), 1'b1, 7, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    update(1'b0, 7, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    lookup(1'b0, 7, 'h1A3, resp(1'b1, 1'b1, 2'd1, 1'b0));
    update(1'b0, 7, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    lookup(1'b0, 7, 'h1A3, resp(1'b1, 1'b1, 2'd0, 1'b1));
    update(1'b0, 7, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    update(1'b0, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    lookup(1'b0, 7, 'h1A3, resp(1'b1, 1'b1, 2'd0, 1'b0));
    update(1'b0, 7, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    update(1'b0, 7, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    lookup(1'b0, 7, 'h1A3, resp(1'b1, 1'b1, 2'd0, 1'b0));
    update(1'b0, 7, 'h0F0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    lookup(1'b0, 7, 'h0F0, resp(1'b0, 1'b1, 2'd0, 1'b1));
    repeat (2) @(negedge clk);
    check("hold_pred_v", 32'(pred_v), 32'd0);
    check("hold_hit", 32'(tag_hit), 32'd1);
    check("hold_new", 32'(new_entry), 32'd1);

    // Small bank: INIT on edges 1-8, RUN 9-24, pass 1 (col 0) 25-32, RUN 33-48, pass 2 (col 1) from 49.
    a_rst = 1'b0;
    wait_ready(1'b1, 8, "a_init_len");
    a_wait_pe(8);
    update(1'b1, 2, 'h0AA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) update(1'b1, 2, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    a_wait_pe(13);
    lookup(1'b1, 2, 'h0AA, resp(1'b1, 1'b1, 2'd3, 1'b0));
    a_wait_pe(39);
    lookup(1'b1, 2, 'h0AA, resp(1'b1, 1'b1, 2'd2, 1'b0));
    a_wait_pe(48);
    update(1'b1, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    update(1'b1, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Two stalled cycles push the clear of entry 2 from edge 51 to edge 53.
    a_wait_pe(51);
    lookup(1'b1, 2, 'h0AA, resp(1'b1, 1'b1, 2'd2, 1'b0));
    lookup(1'b1, 2, 'h0AA, resp(1'b1, 1'b1, 2'd0, 1'b0));
    a_wait_pe(59);
    lookup(1'b1, 2, 'h0AA, resp(1'b1, 1'b1, 2'd0, 1'b0));
    // Pass 3 runs on edges 75-82; reset lands mid-pass.
    a_wait_pe(76);
    lookup(1'b1, 2, 'h0AA, resp(1'b1, 1'b1, 2'd0, 1'b0));
    #2 a_rst = 1'b1;
    #1;
    check("age_rst_ready", 32'(a_ready), 32'd0);
    check("age_rst_pred_v", 32'(a_pred_v), 32'd0);
    check("age_rst_taken", 32'(a_pred_taken), 32'd0);
    check("age_rst_hit", 32'(a_tag_hit), 32'd0);
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    wait_ready(1'b1, 8, "a_reinit_len");
    lookup(1'b1, 2, 0, resp(1'b0, 1'b1, 2'd0, 1'b0));
    lookup(1'b1, 2, 'h0AA, resp(1'b0, 1'b0, 2'd0, 1'b0));

    repeat (3) @(negedge clk);
    check("q_m_drained", 32'(q_m.size()), 32'd0);
    check("q_a_drained", 32'(q_a.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
